interrupt_controller: RTL

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

---
 rtl/interrupt_controller.sv | 84 ++++++++
 1 files changed

// File: rtl/interrupt_controller.sv
// interrupt_controller: edge-triggered lowest-index-first interrupt controller with wfi wakeup; INTERRUPT_MASK_EN adds a mask register
module interrupt_controller #(
  parameter int N_IRQ = 8
) (
  input  logic                     clk,
  input  logic                     nreset,
  input  logic [N_IRQ-1:0]         irq_in,
  input  logic                     wfi,
  input  logic                     interrupt_ack,
  input  logic                     reti,
`ifdef INTERRUPT_MASK_EN
  input  logic                     mask_we,
  input  logic [N_IRQ-1:0]         mask_data,
`endif
  output logic                     interrupt,
  output logic [$clog2(N_IRQ)-1:0] interrupt_no,
  output logic                     wakeup,
  output logic                     error
);
  localparam int W = $clog2(N_IRQ);
  typedef enum logic [1:0] {IDLE, REQUEST, SERVICE} state_t;
  state_t state_q, state_d;
  logic [N_IRQ-1:0] prev_q, pend_q, pend_d, en, act, clr;
  logic [W-1:0] no_q, no_d, sel;
  logic int_q, int_d, wake_q, err_q, err_d;
`ifdef INTERRUPT_MASK_EN
  logic [N_IRQ-1:0] mask_q;
  always_ff @(posedge clk)
    if (!nreset) mask_q <= '0;
    else if (mask_we) mask_q <= mask_data;
  assign en = mask_q;
`else
  assign en = '1;
`endif
  assign act = pend_q & en;
  // a fresh edge in the ack cycle re-arms the line, so set wins over clear
  assign pend_d = (pend_q & ~clr) | (irq_in & ~prev_q);
  always_comb begin
    sel = '0;
    for (int i = N_IRQ - 1; i >= 0; i--)
      if (act[i]) sel = W'(i);
    state_d = state_q;
    int_d = int_q;
    no_d = no_q;
    clr = '0;
    err_d = err_q | (interrupt_ack && state_q != REQUEST) | (reti && state_q != SERVICE);
    case (state_q)
      IDLE: if (|act) begin
        state_d = REQUEST;
        int_d = 1'b1;
        no_d = sel;
      end
      REQUEST: if (interrupt_ack) begin
        state_d = SERVICE;
        int_d = 1'b0;
        clr[no_q] = 1'b1;
      end
      SERVICE: if (reti) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!nreset) begin
      state_q <= IDLE;
      prev_q <= '0;
      pend_q <= '0;
      int_q <= 1'b0;
      no_q <= '0;
      wake_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q <= irq_in;
      pend_q <= pend_d;
      int_q <= int_d;
      no_q <= no_d;
      wake_q <= wfi & (|act);
      err_q <= err_d;
    end
  assign interrupt = int_q;
  assign interrupt_no = no_q;
  assign wakeup = wake_q;
  assign error = err_q;
endmodule
